// File: rtl/act_buffer_nbank.sv
// act_buffer_nbank: N-bank activation SRAM ring between the DMA write path and
// the systolic-array row inputs. The producer fills the bank under wr_ptr and
// commits it; the consumer reads the bank under rd_ptr and releases it. A
// per-bank FILLED bitmap provides the ownership hand-off, so neither side
// drives bank-select lines.
//
// Build option: define ACT_BUF_PARITY_EN to store one even-parity bit per DW
// lane with every word and check it on valid reads (parity_err is sticky).
// Without the macro there is no parity storage and parity_err is tied to 0.
module act_buffer_nbank #(
  parameter int TM         = 14,
  parameter int DW         = 8,
  parameter int ADDR_WIDTH = 7,
  parameter int NBANKS     = 4,
  parameter int RD_LAT     = 1,
  parameter int BW         = $clog2(NBANKS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [TM*DW-1:0]      wr_data,
  input  logic                  wr_commit,
  output logic                  wr_ready,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_release,
  output logic                  rd_bank_valid,
  output logic [TM*DW-1:0]      a_vec,
  output logic                  a_valid,
  output logic [BW-1:0]         wr_bank,
  output logic [BW-1:0]         rd_bank,
  output logic [BW:0]           fill_count,
  output logic                  wr_err,
  output logic                  rd_err,
  output logic                  parity_err
);

  localparam int WW    = TM * DW;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW    = BW + 1;
`ifdef ACT_BUF_PARITY_EN
  localparam int PW    = TM;
`else
  localparam int PW    = 0;
`endif
  // Stored word: {lane parity (optional), data}
  localparam int SW    = WW + PW;

`ifdef ACT_BUF_PARITY_EN
  // Even parity per lane: the bit that makes each DW-bit lane plus parity even.
  function automatic logic [TM-1:0] lane_parity(input logic [WW-1:0] w);
    logic [TM-1:0] p;
    p = '0;
    for (int l = 0; l < TM; l++) begin
      p[l] = ^w[l*DW +: DW];
    end
    return p;
  endfunction
`endif

  // Bank ownership and error state
  logic [NBANKS-1:0] filled_q, filled_d;
  logic [BW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [BW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     fill_cnt_q, fill_cnt_d;
  logic              wr_err_q, wr_err_d;
  logic              rd_err_q, rd_err_d;

  // Qualified actions; clear overrides everything in its cycle
  logic wr_fire, commit_fire, rd_fire, release_fire;

  assign wr_ready      = !filled_q[wr_ptr_q];
  assign rd_bank_valid = filled_q[rd_ptr_q];

  assign wr_fire      = wr_en      && wr_ready      && !clear;
  assign commit_fire  = wr_commit  && wr_ready      && !clear;
  assign rd_fire      = rd_en      && rd_bank_valid && !clear;
  assign release_fire = rd_release && rd_bank_valid && !clear;

  assign wr_bank    = wr_ptr_q;
  assign rd_bank    = rd_ptr_q;
  assign fill_count = fill_cnt_q;
  assign wr_err     = wr_err_q;
  assign rd_err     = rd_err_q;

  // Next-state for bitmap, pointers, fill count and sticky errors. Commit and
  // release can never hit the same bank (one needs FREE, the other FILLED).
  always_comb begin
    filled_d   = filled_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fill_cnt_d = fill_cnt_q;
    wr_err_d   = wr_err_q;
    rd_err_d   = rd_err_q;
    if (clear) begin
      filled_d   = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fill_cnt_d = '0;
      wr_err_d   = 1'b0;
      rd_err_d   = 1'b0;
    end else begin
      if ((wr_en || wr_commit) && !wr_ready) begin
        wr_err_d = 1'b1;
      end
      if ((rd_en || rd_release) && !rd_bank_valid) begin
        rd_err_d = 1'b1;
      end
      if (commit_fire) begin
        filled_d[wr_ptr_q] = 1'b1;
        wr_ptr_d           = wr_ptr_q + BW'(1);
      end
      if (release_fire) begin
        filled_d[rd_ptr_q] = 1'b0;
        rd_ptr_d           = rd_ptr_q + BW'(1);
      end
      case ({commit_fire, release_fire})
        2'b10:   fill_cnt_d = fill_cnt_q + CW'(1);
        2'b01:   fill_cnt_d = fill_cnt_q - CW'(1);
        default: fill_cnt_d = fill_cnt_q;
      endcase
    end
  end

  // Control registers, asynchronously reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filled_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_cnt_q <= '0;
      wr_err_q   <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      filled_q   <= filled_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_cnt_q <= fill_cnt_d;
      wr_err_q   <= wr_err_d;
      rd_err_q   <= rd_err_d;
    end
  end

  // Bank storage, addressed as {bank, word}; contents are never reset
  logic [SW-1:0] mem [0:NBANKS*DEPTH-1];
  logic [SW-1:0] wr_word;

`ifdef ACT_BUF_PARITY_EN
  assign wr_word = {lane_parity(wr_data), wr_data};
`else
  assign wr_word = wr_data;
`endif

  // Write port: a same-cycle commit still lands this word in the old bank
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[{wr_ptr_q, wr_addr}] <= wr_word;
    end
  end

  // ---- stage p1: synchronous array read ----
  logic [SW-1:0] data_p1_q;
  logic          vld_p1_q;

  // Read data register; only loaded by a qualified read
  always_ff @(posedge clk) begin
    if (rd_fire) begin
      data_p1_q <= mem[{rd_ptr_q, rd_addr}];
    end
  end

  // Read valid; clear suppresses the issue, which squashes the read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q <= 1'b0;
    end else begin
      vld_p1_q <= rd_fire;
    end
  end

  // ---- stage p2 (RD_LAT = 2 only): output register ----
  logic [SW-1:0] data_out;
  logic          vld_out;

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic [SW-1:0] data_p2_q;
      logic          vld_p2_q;

      // Output data register, loaded alongside its valid
      always_ff @(posedge clk) begin
        if (vld_p1_q) begin
          data_p2_q <= data_p1_q;
        end
      end

      // Output valid; clear squashes a read already in the p1 stage
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_p2_q <= 1'b0;
        end else begin
          vld_p2_q <= vld_p1_q && !clear;
        end
      end

      assign data_out = data_p2_q;
      assign vld_out  = vld_p2_q;
    end else begin : g_lat1
      assign data_out = data_p1_q;
      assign vld_out  = vld_p1_q;
    end
  endgenerate

  // Zero-gate the output so the array drains zeros on every non-valid cycle;
  // this also makes reset take effect on a_vec immediately.
  assign a_valid = vld_out;
  assign a_vec   = vld_out ? data_out[WW-1:0] : '0;

`ifdef ACT_BUF_PARITY_EN
  logic parity_err_q;
  logic par_mism;

  assign par_mism = vld_out && (data_out[SW-1:WW] != lane_parity(data_out[WW-1:0]));

  // Sticky parity flag; a mismatch also shows on its own data cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err_q <= 1'b0;
    end else if (clear) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= parity_err_q || par_mism;
    end
  end

  assign parity_err = parity_err_q || par_mism;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_act_buffer_nbank.sv
// Bench for act_buffer_nbank: two instances (RD_LAT = 1 and RD_LAT = 2) share
// one stimulus stream and are compared every cycle against a behavioural
// model of bank ownership, memory contents and read latency.
module tb_act_buffer_nbank;
  localparam int TM = 14;
  localparam int DW = 8;
  localparam int AW = 7;
  localparam int NB = 4;
  localparam int BW = 2;
  localparam int WW = TM * DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          clear = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [WW-1:0] wr_data = '0;
  logic          wr_commit = 1'b0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_release = 1'b0;

  logic          wr_ready1, rd_bank_valid1, a_valid1, wr_err1, rd_err1, parity_err1;
  logic [WW-1:0] a_vec1;
  logic [BW-1:0] wr_bank1, rd_bank1;
  logic [BW:0]   fill_count1;
  logic          wr_ready2, rd_bank_valid2, a_valid2, wr_err2, rd_err2, parity_err2;
  logic [WW-1:0] a_vec2;
  logic [BW-1:0] wr_bank2, rd_bank2;
  logic [BW:0]   fill_count2;

  act_buffer_nbank #(.TM(TM), .DW(DW), .ADDR_WIDTH(AW), .NBANKS(NB), .RD_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_commit(wr_commit),
    .wr_ready(wr_ready1), .rd_en(rd_en), .rd_addr(rd_addr), .rd_release(rd_release),
    .rd_bank_valid(rd_bank_valid1), .a_vec(a_vec1), .a_valid(a_valid1),
    .wr_bank(wr_bank1), .rd_bank(rd_bank1), .fill_count(fill_count1),
    .wr_err(wr_err1), .rd_err(rd_err1), .parity_err(parity_err1)
  );

  act_buffer_nbank #(.TM(TM), .DW(DW), .ADDR_WIDTH(AW), .NBANKS(NB), .RD_LAT(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_commit(wr_commit),
    .wr_ready(wr_ready2), .rd_en(rd_en), .rd_addr(rd_addr), .rd_release(rd_release),
    .rd_bank_valid(rd_bank_valid2), .a_vec(a_vec2), .a_valid(a_valid2),
    .wr_bank(wr_bank2), .rd_bank(rd_bank2), .fill_count(fill_count2),
    .wr_err(wr_err2), .rd_err(rd_err2), .parity_err(parity_err2)
  );

  always #5 clk = ~clk;

  // Reference model state (only word addresses 0..7 are exercised)
  bit            m_filled [NB];
  int            m_wp, m_rp;
  bit            m_werr, m_rerr;
  logic [WW-1:0] m_mem [NB][8];
  bit            m_bad [NB][8];
  // Read results 1 and 2 cycles after issue
  bit            v1, v2, b1, b2;
  logic [WW-1:0] d1, d2;
  bit            m_perr1, m_perr2;

  int    tests = 0;
  int    fails = 0;
  string phase = "reset";

  function automatic logic [WW-1:0] rnd_word();
    logic [127:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom()};
    return t[WW-1:0];
  endfunction

  task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int cnt;
    cnt = 0;
    foreach (m_filled[i]) cnt += int'(m_filled[i]);
    chk({phase, ":wr_ready1"},      WW'(wr_ready1),      WW'(!m_filled[m_wp]));
    chk({phase, ":wr_ready2"},      WW'(wr_ready2),      WW'(!m_filled[m_wp]));
    chk({phase, ":rd_bank_valid1"}, WW'(rd_bank_valid1), WW'(m_filled[m_rp]));
    chk({phase, ":rd_bank_valid2"}, WW'(rd_bank_valid2), WW'(m_filled[m_rp]));
    chk({phase, ":wr_bank1"},       WW'(wr_bank1),       WW'(m_wp));
    chk({phase, ":wr_bank2"},       WW'(wr_bank2),       WW'(m_wp));
    chk({phase, ":rd_bank1"},       WW'(rd_bank1),       WW'(m_rp));
    chk({phase, ":rd_bank2"},       WW'(rd_bank2),       WW'(m_rp));
    chk({phase, ":fill_count1"},    WW'(fill_count1),    WW'(cnt));
    chk({phase, ":fill_count2"},    WW'(fill_count2),    WW'(cnt));
    chk({phase, ":wr_err1"},        WW'(wr_err1),        WW'(m_werr));
    chk({phase, ":wr_err2"},        WW'(wr_err2),        WW'(m_werr));
    chk({phase, ":rd_err1"},        WW'(rd_err1),        WW'(m_rerr));
    chk({phase, ":rd_err2"},        WW'(rd_err2),        WW'(m_rerr));
    chk({phase, ":a_valid1"},       WW'(a_valid1),       WW'(v1));
    chk({phase, ":a_valid2"},       WW'(a_valid2),       WW'(v2));
    chk({phase, ":a_vec1"},         a_vec1,              v1 ? d1 : '0);
    chk({phase, ":a_vec2"},         a_vec2,              v2 ? d2 : '0);
    chk({phase, ":parity_err1"},    WW'(parity_err1),    WW'(m_perr1 || (v1 && b1)));
    chk({phase, ":parity_err2"},    WW'(parity_err2),    WW'(m_perr2 || (v2 && b2)));
  endtask

  task automatic model_reset();
    foreach (m_filled[i]) m_filled[i] = 1'b0;
    m_wp = 0; m_rp = 0; m_werr = 1'b0; m_rerr = 1'b0;
    v1 = 1'b0; v2 = 1'b0; b1 = 1'b0; b2 = 1'b0;
    m_perr1 = 1'b0; m_perr2 = 1'b0;
  endtask

  // Apply the ownership rules for the inputs now on the wires
  task automatic model_step();
    bit            ok_w, ok_r, nv, nb;
    logic [WW-1:0] nd;
    ok_w = !m_filled[m_wp];
    ok_r = m_filled[m_rp];
    if (clear) begin
      model_reset();
      return;
    end
    m_perr1 = m_perr1 || (v1 && b1);
    m_perr2 = m_perr2 || (v2 && b2);
    nv = 1'b0; nb = 1'b0; nd = '0;
    if (rd_en) begin
      if (ok_r) begin
        nv = 1'b1;
        nd = m_mem[m_rp][rd_addr[2:0]];
        nb = m_bad[m_rp][rd_addr[2:0]];
      end else begin
        m_rerr = 1'b1;
      end
    end
    if (rd_release) begin
      if (ok_r) begin
        m_filled[m_rp] = 1'b0;
        m_rp = (m_rp + 1) % NB;
      end else begin
        m_rerr = 1'b1;
      end
    end
    if (wr_en) begin
      if (ok_w) begin
        m_mem[m_wp][wr_addr[2:0]] = wr_data;
        m_bad[m_wp][wr_addr[2:0]] = 1'b0;
      end else begin
        m_werr = 1'b1;
      end
    end
    if (wr_commit) begin
      if (ok_w) begin
        m_filled[m_wp] = 1'b1;
        m_wp = (m_wp + 1) % NB;
      end else begin
        m_werr = 1'b1;
      end
    end
    v2 = v1; d2 = d1; b2 = b1;
    v1 = nv; d1 = nd; b1 = nb;
  endtask

  task automatic cyc(input bit c, input bit we, input int wa, input logic [WW-1:0] wd,
                     input bit wc, input bit re, input int ra, input bit rr);
    clear = c; wr_en = we; wr_addr = AW'(wa); wr_data = wd; wr_commit = wc;
    rd_en = re; rd_addr = AW'(ra); rd_release = rr;
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, '0, 0, 0, 0, 0);
  endtask

  // Fill the bank under the write pointer at words 0..n-1 and commit with the last word
  task automatic fill_bank(input int n);
    for (int a = 0; a < n; a++) cyc(0, 1, a, rnd_word(), a == n - 1, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    foreach (m_bad[b, a]) m_bad[b][a] = 1'b0;
    model_reset();
    #1 rst_n = 1'b0;
    #1 check_all();
    @(posedge clk);
    #1 rst_n = 1'b1;
    check_all();

    // Known contents in words 0..7 of every bank; read+release in one cycle
    phase = "prep";
    for (int b = 0; b < NB; b++) fill_bank(8);
    for (int b = 0; b < NB; b++) cyc(0, 0, 0, '0, 0, 1, b, 1);
    idle(2);

    phase = "tp1_basic";
    fill_bank(3);
    for (int a = 0; a < 3; a++) cyc(0, 0, 0, '0, 0, 1, a, 0);
    idle(3);

    phase = "tp2_full";
    for (int b = 1; b < NB; b++) fill_bank(8);
    cyc(0, 1, 1, rnd_word(), 0, 0, 0, 0);
    cyc(0, 0, 0, '0, 1, 0, 0, 0);
    for (int a = 0; a < 3; a++) cyc(0, 0, 0, '0, 0, 1, a, 0);
    cyc(0, 0, 0, '0, 0, 0, 0, 1);
    idle(2);

    phase = "tp3_commit_release";
    cyc(0, 0, 0, '0, 0, 1, 5, 1);
    cyc(0, 1, 0, rnd_word(), 1, 1, 6, 1);
    idle(2);

    phase = "clear_prio";
    cyc(1, 1, 2, rnd_word(), 1, 1, 0, 1);
    idle(1);

    phase = "random";
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(63) == 0, $urandom_range(1) == 1, $urandom_range(7), rnd_word(),
          $urandom_range(5) == 0, $urandom_range(1) == 1, $urandom_range(7),
          $urandom_range(5) == 0);
    end
    idle(2);

    phase = "empty_read";
    cyc(1, 0, 0, '0, 0, 0, 0, 0);
    cyc(0, 0, 0, '0, 0, 1, 3, 0);
    cyc(0, 0, 0, '0, 0, 0, 0, 1);
    idle(3);

    phase = "clear_inflight";
    cyc(1, 0, 0, '0, 0, 0, 0, 0);
    fill_bank(2);
    cyc(0, 0, 0, '0, 0, 1, 0, 0);
    cyc(1, 0, 0, '0, 0, 0, 0, 0);
    idle(3);

    phase = "async_reset";
    fill_bank(3);
    cyc(0, 0, 0, '0, 0, 1, 0, 0);
    cyc(0, 0, 0, '0, 0, 1, 1, 0);
    clear = 1'b0; wr_en = 1'b0; wr_commit = 1'b0; rd_en = 1'b0; rd_release = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1 check_all();
    @(posedge clk);
    #1 rst_n = 1'b1;
    check_all();
    idle(2);

`ifdef ACT_BUF_PARITY_EN
    phase = "parity";
    fill_bank(3);
    u_dut1.mem[1][0] = ~u_dut1.mem[1][0];
    u_dut2.mem[1][0] = ~u_dut2.mem[1][0];
    m_mem[0][1][0] = ~m_mem[0][1][0];
    m_bad[0][1] = 1'b1;
    cyc(0, 0, 0, '0, 0, 1, 0, 0);
    cyc(0, 0, 0, '0, 0, 1, 1, 0);
    cyc(0, 0, 0, '0, 0, 1, 2, 0);
    idle(3);
    cyc(1, 0, 0, '0, 0, 0, 0, 0);
    idle(2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
